// File: rtl/gen_timer_pkg.sv
// Shared state encoding and mode constants for the multi-channel timer.
package gen_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/gen_timer_ch.sv
// One timer channel: one-shot level flag or periodic pulse after tv_r+1 cycles.
// All outputs are flops; no input-to-output combinational path, no backpressure.
module gen_timer_ch #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [CW-1:0] trig_val,
  output logic          f,
  output logic          busy,
  output logic [CW-1:0] cnt
);
  import gen_timer_pkg::*;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tv_q, tv_d;
  logic          md_q, md_d;
  logic          f_q, f_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tv_d    = tv_q;
    md_d    = md_q;
    f_d     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tv_d    = trig_val;
          md_d    = mode;
          cnt_d   = '0;
          state_d = COUNT;
        end
        COUNT: begin
          // cnt stops at tv_q, so an all-ones trigger never wraps the counter
          if (cnt_q != tv_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (md_q == MODE_ONESHOT) begin
            f_d     = 1'b1;
            state_d = DONE;
          end else begin
            f_d   = 1'b1;
            cnt_d = '0;
            tv_d  = trig_val;
          end
        end
        DONE: begin
          f_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tv_q    <= '0;
      md_q    <= MODE_ONESHOT;
      f_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      md_q    <= md_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
    end
  end

  assign f    = f_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/gen_timer_multi.sv
// NCH independent timer channels sharing one clock and reset.
// Outputs registered inside each channel; inputs are sampled every cycle, no backpressure.
module gen_timer_multi #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*CW-1:0] trig_val,
  output logic [NCH-1:0]    f,
  output logic [NCH-1:0]    busy,
  output logic [NCH*CW-1:0] cnt
);
  import gen_timer_pkg::*;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gen_timer_ch #(
      .CW(CW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .mode     (mode[g]),
      .trig_val (trig_val[g*CW +: CW]),
      .f        (f[g]),
      .busy     (busy[g]),
      .cnt      (cnt[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_gen_timer_multi.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_gen_timer_multi;
  import gen_timer_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    mode;
  logic [NCH*CW-1:0] trig_val;
  logic [NCH-1:0]    f;
  logic [NCH-1:0]    busy;
  logic [NCH*CW-1:0] cnt;

  gen_timer_multi #(.NCH(NCH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .trig_val (trig_val),
    .f        (f),
    .busy     (busy),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    ch;
    bit    f;
    bit    busy;
    int    cnt;
    string nm;
  } exp_t;

  exp_t sbq[$];
  exp_t keep[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0, t1, t2;

  // cyc equals the number of rising edges seen; stable at every negedge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int ch, input bit fe, input bit be, input int ce);
    logic [CW-1:0] ca;
    logic [CW-1:0] cw;
    ca = cnt[ch*CW +: CW];
    cw = ce[CW-1:0];
    checks++;
    if (f[ch] !== fe || busy[ch] !== be || ca !== cw) begin
      errors++;
      $display("FAIL %s ch%0d cyc=%0d: got f=%b busy=%b cnt=%0d, want f=%b busy=%b cnt=%0d",
               nm, ch, cyc, f[ch], busy[ch], ca, fe, be, cw);
    end
  endtask

  task automatic expect_at(input int c, input int ch, input bit fe, input bit be, input int ce,
                           input string nm);
    exp_t e;
    e.cyc = c; e.ch = ch; e.f = fe; e.busy = be; e.cnt = ce; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic set_ch(input int ch, input logic m, input int tv);
    mode[ch] = m;
    trig_val[ch*CW +: CW] = tv[CW-1:0];
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every expectation due this cycle, flag any that were skipped
  initial begin
    forever begin
      @(negedge clk);
      keep = {};
      foreach (sbq[i]) begin
        if (sbq[i].cyc == cyc) begin
          chk(sbq[i].nm, sbq[i].ch, sbq[i].f, sbq[i].busy, sbq[i].cnt);
        end else if (sbq[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s ch%0d missed: due cyc=%0d, now cyc=%0d", sbq[i].nm, sbq[i].ch,
                   sbq[i].cyc, cyc);
        end else begin
          keep.push_back(sbq[i]);
        end
      end
      sbq = keep;
    end
  end

  initial begin
    rst      = 1'b1;
    en       = '0;
    mode     = '0;
    trig_val = '0;
    #1;
    for (int ch = 0; ch < NCH; ch++) chk("reset_state", ch, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All four channels armed on the same edge with different settings
    t0 = cyc;
    set_ch(0, MODE_ONESHOT, 10);
    set_ch(1, MODE_PERIODIC, 3);
    set_ch(2, MODE_ONESHOT, 100);
    set_ch(3, MODE_PERIODIC, 5);
    en = 4'hF;

    expect_at(t0+1,  0, 0, 1, 0,  "os_arm");
    expect_at(t0+8,  0, 0, 1, 7,  "os_ignore_tv");
    expect_at(t0+11, 0, 0, 1, 10, "os_before_fire");
    expect_at(t0+12, 0, 1, 0, 10, "os_fire");
    expect_at(t0+30, 0, 1, 0, 10, "os_hold");

    expect_at(t0+1,  1, 0, 1, 0, "per_arm");
    expect_at(t0+4,  1, 0, 1, 3, "per_top");
    expect_at(t0+5,  1, 1, 1, 0, "per_pulse1");
    expect_at(t0+6,  1, 0, 1, 1, "per_pulse_end");
    expect_at(t0+9,  1, 1, 1, 0, "per_pulse2");
    expect_at(t0+13, 1, 1, 1, 0, "per_pulse3");

    expect_at(t0+41, 2, 0, 1, 40, "drop_cnt40");
    expect_at(t0+42, 2, 0, 0, 0,  "drop_idle");
    expect_at(t0+45, 2, 0, 1, 0,  "drop_rearm");
    expect_at(t0+47, 2, 0, 1, 2,  "drop_recount");

    expect_at(t0+6,  3, 0, 1, 5, "rld_top5");
    expect_at(t0+7,  3, 1, 1, 0, "rld_wrap6");
    expect_at(t0+8,  3, 0, 1, 1, "rld_cnt1");
    expect_at(t0+9,  3, 0, 1, 2, "rld_top2");
    expect_at(t0+10, 3, 1, 1, 0, "rld_wrap3");
    expect_at(t0+12, 3, 0, 1, 2, "rld_top2b");
    expect_at(t0+13, 3, 1, 1, 0, "rld_wrap3b");

    wait_to(t0+3);
    set_ch(0, MODE_PERIODIC, 7);
    set_ch(3, MODE_PERIODIC, 2);
    wait_to(t0+41);
    en[2] = 1'b0;
    wait_to(t0+44);
    en[2] = 1'b1;
    wait_to(t0+60);

    // Async reset between edges with every channel busy or done, en held high
    set_ch(0, MODE_ONESHOT, 0);
    set_ch(1, MODE_PERIODIC, 0);
    set_ch(2, MODE_ONESHOT, 5);
    set_ch(3, MODE_PERIODIC, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int ch = 0; ch < NCH; ch++) chk("async_rst", ch, 1'b0, 1'b0, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // First edge after release is the arm edge for every channel
    t1 = cyc;
    expect_at(t1+1, 0, 0, 1, 0, "zero_os_arm");
    expect_at(t1+2, 0, 1, 0, 0, "zero_os_fire");
    expect_at(t1+5, 0, 1, 0, 0, "zero_os_hold");
    expect_at(t1+1, 1, 0, 1, 0, "zero_per_arm");
    for (int k = 2; k <= 6; k++) expect_at(t1+k, 1, 1, 1, 0, "zero_per_cont");
    expect_at(t1+1, 2, 0, 1, 0, "indep_arm5");
    expect_at(t1+6, 2, 0, 1, 5, "indep_top5");
    expect_at(t1+7, 2, 1, 0, 5, "indep_fire5");
    expect_at(t1+1, 3, 0, 1, 0, "indep_arm1");
    expect_at(t1+2, 3, 0, 1, 1, "indep_p1_top");
    expect_at(t1+3, 3, 1, 1, 0, "indep_p1_wrap");
    expect_at(t1+4, 3, 0, 1, 1, "indep_p1_top2");
    expect_at(t1+5, 3, 1, 1, 0, "indep_p1_wrap2");

    wait_to(t1+10);
    en[0] = 1'b0;
    expect_at(t1+11, 0, 0, 0, 0, "done_en_drop");
    wait_to(t1+12);

    // Maximum trigger value: count reaches all ones and stops there
    t2 = cyc;
    set_ch(0, MODE_ONESHOT, 65535);
    en[0] = 1'b1;
    expect_at(t2+1,     0, 0, 1, 0,     "max_arm");
    expect_at(t2+65536, 0, 0, 1, 65535, "max_top");
    expect_at(t2+65537, 0, 1, 0, 65535, "max_fire");
    expect_at(t2+65541, 0, 1, 0, 65535, "max_no_wrap");
    wait_to(t2+65543);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_timer_multi.md
GEN_TIMER_MULTI -- requirements
Module: gen_timer_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent timer channels (1..32).
REQ-002 Parameter CW, default 16, counter and trigger-value width in bits (2..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  NCH  per-channel enable; bit i controls channel i.
REQ-006 mode  input  NCH  per-channel mode; 0 = one-shot, 1 = periodic.
REQ-007 trig_val  input  NCH*CW  per-channel trigger value; channel i occupies bits [i*CW +: CW].
REQ-008 f  output  NCH  per-channel flag: a level in one-shot mode, a pulse in periodic mode.
REQ-009 busy  output  NCH  per-channel high while the channel is in state COUNT.
REQ-010 cnt  output  NCH*CW  per-channel current count, packed the same way as trig_val.

Function
REQ-011 Each channel SHALL have three states, IDLE, COUNT and DONE, and SHALL operate independently of every other channel.
REQ-012 In any state, en[i]=0 at a rising edge SHALL move the channel to IDLE with cnt=0 and f=0.
REQ-013 In IDLE with en[i]=1 (arm edge), the channel SHALL capture trig_val[i] into tv_r and mode[i] into md_r, set cnt=0, and enter COUNT.
REQ-014 In COUNT with cnt<tv_r, the channel SHALL increment cnt by 1 at each edge.
REQ-015 In COUNT with cnt==tv_r and md_r=0, the channel SHALL set f=1, hold cnt, and enter DONE; f therefore rises tv_r+1 edges after the arm edge.
REQ-016 In COUNT with cnt==tv_r and md_r=1, the channel SHALL set f=1 for exactly one cycle, set cnt=0, reload tv_r from trig_val[i], and stay in COUNT; the pulse period is tv_r+1 cycles.
REQ-017 In COUNT, f SHALL be 0 on every edge where REQ-016 does not apply.
REQ-018 In DONE, f SHALL stay 1 and cnt SHALL stay tv_r until en[i] falls.
REQ-019 Changes to trig_val[i] or mode[i] while a channel is in COUNT or DONE SHALL be ignored, except for the periodic reload at the wrap edge (REQ-016).
REQ-020 With tv_r=0 in one-shot mode, f SHALL rise at the edge after the arm edge.
REQ-021 With tv_r=0 in periodic mode, f SHALL be 1 on every cycle from the edge after the arm edge onward.
REQ-022 cnt SHALL never exceed tv_r; no overflow or wrap past 2^CW-1 SHALL occur, including when trig_val = all ones.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-024 While rst=1, every channel SHALL immediately be in IDLE with cnt=0, f=0, busy=0, tv_r=0 and md_r=0, regardless of clk.
REQ-025 Reset asserted in the middle of an operation SHALL abort that operation.
REQ-026 After rst falls, the first rising edge with en[i]=1 SHALL be the arm edge for channel i.

Structure
REQ-027 The package gen_timer_pkg SHALL hold the state encoding (IDLE, COUNT, DONE) and the mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
REQ-028 The per-channel logic SHALL be a sub-module gen_timer_ch, parameterised by CW; the top level SHALL instantiate it NCH times with a generate loop.

Verification
REQ-029 Scenario (one-shot): NCH=4, CW=16, ch0 mode=0, trig_val=10, en raised -> f[0] rises exactly 11 edges after the arm edge, stays 1, and cnt=10 holds.
REQ-030 Scenario (periodic): ch1 mode=1, trig_val=3 -> f[1] is a one-cycle pulse every 4 cycles, cnt cycles 0,1,2,3, and busy[1] stays 1.
REQ-031 Scenario (en drop): ch2 trig_val=100, en dropped at cnt=40 -> next edge gives cnt=0, f=0, busy=0; re-arming restarts the count from 0.
REQ-032 Scenario (reload): ch3 periodic, trig_val changed 5->2 mid-count -> current period completes at 6 cycles, the following periods are 3 cycles.
REQ-033 Scenario (zero and max): trig_val=0, one-shot -> f rises 1 edge after arm; trig_val=0, periodic -> f continuously 1; trig_val=16'hFFFF -> f after 65536 edges, with no wrap of cnt.
REQ-034 Scenario (async reset): rst pulsed between clock edges with all channels active -> all outputs 0 before the next edge; channels independent under simultaneous arming with different values.
